// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write side: Gray/binary conversion and
// channel-select width. Conversions work on 32-bit zero-extended values.
package fifo_pkg;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wptr_full_ch.sv
// One write-side channel: binary/Gray write pointer, registered full,
// almost-full and level, plus sticky overflow and saturating drop counter.
module fifo_wptr_full_ch
   import fifo_pkg::*;
#(
   parameter int  F_DEPTH  = 4,
   parameter int  AF_LEVEL = 3,
   parameter int  CNT_W    = 8,
   localparam int A_W      = $clog2(F_DEPTH),
   localparam int P_SIZE   = A_W + 1
) (
   input  logic              w_clk,
   input  logic              w_rstn,
   input  logic              w_inc,
   input  logic [P_SIZE-1:0] wq2_rptr,
   input  logic              w_ovf_clr,
   output logic [P_SIZE-1:0] w_ptr_gray,
   output logic              w_full,
   output logic              w_almost_full,
   output logic [P_SIZE-1:0] w_level,
   output logic              w_ovf,
   output logic [CNT_W-1:0]  w_drop_cnt,
   output logic              w_acc,
   output logic [A_W-1:0]    w_addr
);

   // Full when the write Gray pointer equals the read pointer with its two MSBs inverted.
   localparam logic [P_SIZE-1:0] FULL_MASK = P_SIZE'(3) << (P_SIZE - 2);
   localparam logic [P_SIZE-1:0] AF_THR    = P_SIZE'(AF_LEVEL);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [P_SIZE-1:0] wbin, wbin_nxt, wgray_nxt, rbin, level_nxt;
   logic [31:0]       gray_ext, rbin_ext;
   logic              drop;
   logic              unused_hi;

   // Handshake: w_inc is a request; it is accepted only while w_full is low
   // (ready = ~w_full). A request seen while full is dropped and counted.
   always_comb begin
      w_acc     = w_inc & ~w_full;
      drop      = w_inc & w_full;
      wbin_nxt  = wbin + P_SIZE'(w_acc);
      gray_ext  = bin2gray(32'(wbin_nxt));
      wgray_nxt = gray_ext[P_SIZE-1:0];
      rbin_ext  = gray2bin(32'(wq2_rptr));
      rbin      = rbin_ext[P_SIZE-1:0];
      level_nxt = wbin_nxt - rbin;
   end

   assign w_addr    = wbin[A_W-1:0];
   assign unused_hi = ^{gray_ext[31:P_SIZE], rbin_ext[31:P_SIZE]};

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         wbin          <= '0;
         w_ptr_gray    <= '0;
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_level       <= '0;
         w_ovf         <= 1'b0;
         w_drop_cnt    <= '0;
      end else begin
         wbin          <= wbin_nxt;
         w_ptr_gray    <= wgray_nxt;
         w_full        <= (wgray_nxt == (wq2_rptr ^ FULL_MASK));
         w_level       <= level_nxt;
         w_almost_full <= (level_nxt >= AF_THR);
         // Clear beats a same-cycle drop for the flag, but the drop still counts.
         if (w_ovf_clr) begin
            w_ovf      <= 1'b0;
            w_drop_cnt <= drop ? CNT_W'(1) : '0;
         end else if (drop) begin
            w_ovf <= 1'b1;
            if (w_drop_cnt != CNT_MAX) w_drop_cnt <= w_drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fifo_mem_write_mc.sv
// Multi-channel async FIFO write side: per-channel storage and pointer logic
// in one write clock domain, with an asynchronous read port for the read side.
module fifo_mem_write_mc
   import fifo_pkg::*;
#(
   parameter int  D_SIZE   = 16,
   parameter int  F_DEPTH  = 4,
   parameter int  N_CH     = 2,
   parameter int  AF_LEVEL = 3,
   parameter int  CNT_W    = 8,
   localparam int A_W      = $clog2(F_DEPTH),
   localparam int P_SIZE   = A_W + 1,
   localparam int CH_W     = ch_width(N_CH)
) (
   input  logic                     w_clk,
   input  logic                     w_rstn,
   input  logic [N_CH-1:0]          w_inc,
   input  logic [N_CH*D_SIZE-1:0]   w_data,
   input  logic [N_CH*P_SIZE-1:0]   wq2_rptr,
   input  logic [N_CH-1:0]          w_ovf_clr,
   output logic [N_CH*P_SIZE-1:0]   w_ptr_gray,
   output logic [N_CH-1:0]          w_full,
   output logic [N_CH-1:0]          w_almost_full,
   output logic [N_CH*P_SIZE-1:0]   w_level,
   output logic [N_CH-1:0]          w_ovf,
   output logic [N_CH*CNT_W-1:0]    w_drop_cnt,
   input  logic [CH_W-1:0]          r_ch,
   input  logic [A_W-1:0]           r_addr,
   output logic [D_SIZE-1:0]        r_data
);

   logic [D_SIZE-1:0]   mem [N_CH][F_DEPTH];
   logic [N_CH-1:0]     acc;
   logic [N_CH*A_W-1:0] waddr;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      fifo_wptr_full_ch #(
         .F_DEPTH  (F_DEPTH),
         .AF_LEVEL (AF_LEVEL),
         .CNT_W    (CNT_W)
      ) u_ch (
         .w_clk         (w_clk),
         .w_rstn        (w_rstn),
         .w_inc         (w_inc[c]),
         .wq2_rptr      (wq2_rptr[c*P_SIZE +: P_SIZE]),
         .w_ovf_clr     (w_ovf_clr[c]),
         .w_ptr_gray    (w_ptr_gray[c*P_SIZE +: P_SIZE]),
         .w_full        (w_full[c]),
         .w_almost_full (w_almost_full[c]),
         .w_level       (w_level[c*P_SIZE +: P_SIZE]),
         .w_ovf         (w_ovf[c]),
         .w_drop_cnt    (w_drop_cnt[c*CNT_W +: CNT_W]),
         .w_acc         (acc[c]),
         .w_addr        (waddr[c*A_W +: A_W])
      );
   end

   always_ff @(posedge w_clk or negedge w_rstn) begin
      if (!w_rstn) begin
         for (int c = 0; c < N_CH; c++) begin
            for (int a = 0; a < F_DEPTH; a++) begin
               mem[c][a] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (acc[c]) mem[c][waddr[c*A_W +: A_W]] <= w_data[c*D_SIZE +: D_SIZE];
         end
      end
   end

   // Read port is combinational; an out-of-range channel reads as zero.
   always_comb begin
      r_data = '0;
      if (int'(r_ch) < N_CH) r_data = mem[r_ch][r_addr];
   end

endmodule
